spike_event_logger: RTL and testbench

SPIKE_EVENT_LOGGER -- requirements
Module: spike_event_logger

---
 rtl/spike_event_logger.sv | 107 ++++++++++
 tb/tb_spike_event_logger.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/spike_event_logger.sv
// Windowed spike event logger: timestamps events into a FIFO
// during a fixed-length window, then drains them on request.
module spike_event_logger #(
  parameter int DEPTH    = 16,
  parameter int WINDOW   = 1024,
  parameter int ID_WIDTH = 16
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_n_i,
  input  logic                    start_logging,
  input  logic                    event_valid_i,
  input  logic [ID_WIDTH-1:0]     event_id_i,
  input  logic                    rd_req_i,
  output logic [16+ID_WIDTH-1:0]  rd_data_o,
  output logic                    rd_valid_o,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [7:0]              dropped_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int DW = 16 + ID_WIDTH;
  localparam logic [15:0] LAST = 16'(WINDOW - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOG  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [15:0]   ts;

  logic full;
  logic empty;
  logic do_start;
  logic do_wr;
  logic do_rd;

  assign full     = (count_o == CW'(DEPTH));
  assign empty    = (count_o == '0);
  assign do_start = start_logging && (state != LOG);
  assign do_wr    = (state == LOG) && event_valid_i && !full;
  assign do_rd    = (state == DONE) && rd_req_i && !empty;

  // Buffer storage; contents survive reset on purpose
  always_ff @(posedge wb_clk_i) begin
    if (do_wr) mem[wr_ptr] <= {ts, event_id_i};
  end

  // Run control, pointers, counters and registered status
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_o    <= '0;
      dropped_o  <= '0;
      ts         <= '0;
      rd_data_o  <= '0;
      rd_valid_o <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      rd_valid_o <= 1'b0;
      unique case (1'b1)
        do_start: begin
          state     <= LOG;
          busy_o    <= 1'b1;
          done_o    <= 1'b0;
          wr_ptr    <= '0;
          rd_ptr    <= '0;
          count_o   <= '0;
          dropped_o <= '0;
          ts        <= '0;
        end
        (state == LOG): begin
          ts <= ts + 16'd1;
          if (do_wr) begin
            wr_ptr  <= wr_ptr + AW'(1);
            count_o <= count_o + CW'(1);
          end else if (event_valid_i && dropped_o != 8'hFF) begin
            dropped_o <= dropped_o + 8'd1;
          end
          if (ts == LAST) begin
            state  <= DONE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
          end
        end
        do_rd: begin
          rd_data_o  <= mem[rd_ptr];
          rd_valid_o <= 1'b1;
          rd_ptr     <= rd_ptr + AW'(1);
          count_o    <= count_o - CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spike_event_logger.sv
// Scoreboard bench for spike_event_logger: directed runs,
// expected pops queued by stimulus, checked by a monitor.
module tb_spike_event_logger;

  localparam int DEPTH  = 16;
  localparam int WINDOW = 32;
  localparam int IDW    = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic            ev;
  logic [IDW-1:0]  id;
  logic            rd_req;
  logic [31:0]     rd_data;
  logic            rd_valid;
  logic [4:0]      count;
  logic            busy;
  logic            done;
  logic [7:0]      dropped;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] q[$];

  always #5 clk = ~clk;

  spike_event_logger #(
    .DEPTH(DEPTH),
    .WINDOW(WINDOW),
    .ID_WIDTH(IDW)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_n_i(rst_n),
    .start_logging(start),
    .event_valid_i(ev),
    .event_id_i(id),
    .rd_req_i(rd_req),
    .rd_data_o(rd_data),
    .rd_valid_o(rd_valid),
    .count_o(count),
    .busy_o(busy),
    .done_o(done),
    .dropped_o(dropped)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every rd_valid pulse must match the next queued entry
  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_pop: got %h expected none", rd_data);
      end else begin
        chk("rd_data", rd_data, q.pop_front());
      end
    end
  end

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    ev     = 1'b0;
    id     = '0;
    rd_req = 1'b0;
    repeat (2) cyc();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_count", count, 0);
    chk("rst_dropped", dropped, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    rst_n = 1'b1;
    cyc();

    // Two events at ts 2 and 5, window length check
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int t = 0; t < WINDOW; t++) begin
      ev = (t == 2 || t == 5);
      id = (t == 2) ? 16'h0011 : 16'h0022;
      if (t == 0 || t == WINDOW - 1) begin
        chk("win_busy", busy, 1);
        chk("win_done", done, 0);
      end
      cyc();
    end
    ev = 1'b0;
    chk("t1_done", done, 1);
    chk("t1_busy", busy, 0);
    chk("t1_count", count, 2);
    q.push_back(32'h0002_0011);
    q.push_back(32'h0005_0022);
    rd_req = 1'b1;
    cyc();
    cyc();
    rd_req = 1'b0;
    cyc();
    chk("t1_count_after", count, 0);
    chk("t1_still_done", done, 1);

    // Concurrent start+event ignored, then full buffer overflow
    start = 1'b1;
    ev    = 1'b1;
    id    = 16'hBEEF;
    cyc();
    start = 1'b0;
    for (int t = 0; t < WINDOW; t++) begin
      ev = 1'b1;
      id = 16'(t);
      cyc();
    end
    ev = 1'b0;
    chk("t2_count", count, 16);
    chk("t2_dropped", dropped, 16);
    for (int t = 0; t < 16; t++) q.push_back({16'(t), 16'(t)});
    rd_req = 1'b1;
    repeat (16) cyc();
    cyc();
    rd_req = 1'b0;
    chk("t2_empty_rd_valid", rd_valid, 0);
    chk("t2_hold_rd_data", rd_data, 32'h000F_000F);
    chk("t2_count_after", count, 0);

    // Run A: 12 events, 12 reads
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int t = 0; t < WINDOW; t++) begin
      ev = (t < 12);
      id = 16'h0100 + 16'(t);
      if (t < 12) q.push_back({16'(t), 16'h0100 + 16'(t)});
      cyc();
    end
    ev = 1'b0;
    chk("ra_count", count, 12);
    rd_req = 1'b1;
    repeat (12) cyc();
    rd_req = 1'b0;
    cyc();
    chk("ra_count_after", count, 0);

    // Run B: 12 events, mid-LOG start pulse must be ignored
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int t = 0; t < WINDOW; t++) begin
      start = (t == 3);
      ev    = (t >= 10 && t < 22);
      id    = 16'h0200 + 16'(t);
      if (t >= 10 && t < 22) q.push_back({16'(t), 16'h0200 + 16'(t)});
      if (t == WINDOW - 1) chk("rb_busy_last", busy, 1);
      cyc();
    end
    start = 1'b0;
    ev    = 1'b0;
    chk("rb_done", done, 1);
    chk("rb_count", count, 12);
    rd_req = 1'b1;
    repeat (12) cyc();
    rd_req = 1'b0;
    cyc();

    // Restart from DONE with 5 unread entries
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int t = 0; t < WINDOW; t++) begin
      ev = (t < 5);
      id = 16'h0300 + 16'(t);
      cyc();
    end
    ev = 1'b0;
    chk("rc_count", count, 5);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("restart_count", count, 0);
    chk("restart_busy", busy, 1);
    chk("restart_done", done, 0);

    // Asynchronous reset mid-LOG
    for (int t = 0; t < 3; t++) begin
      ev = 1'b1;
      id = 16'h0400 + 16'(t);
      cyc();
    end
    ev = 1'b0;
    chk("pre_rst_count", count, 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_busy", busy, 0);
    chk("async_count", count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    rd_req = 1'b1;
    ev     = 1'b1;
    repeat (4) cyc();
    rd_req = 1'b0;
    ev     = 1'b0;
    chk("post_rst_rd_valid", rd_valid, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_done", done, 0);
    chk("idle_event_count", count, 0);
    cyc();
    chk("queue_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
